sd_block_sequencer: RTL and testbench

//  Multi-sector SD transfer sequencer between a host byte stream and sd_controller (SPI mode).

---
 rtl/sd_block_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_sequencer.sv
// Multi-sector SD burst sequencer: stages host write bytes through a small FIFO,
// streams read bytes out, and walks sd_controller through CMD_COUNT sectors.
module sd_block_sequencer #(
  parameter int BLOCK_BYTES = 512,
  parameter int ADDR_STEP   = 512,
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_lba,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error,
  output logic [CNT_W-1:0] sectors_done,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [7:0]       sd_din,
  output logic [31:0]      sd_address,
  input  logic [7:0]       sd_dout,
  input  logic             sd_byte_avail,
  input  logic             sd_ready,
  input  logic             sd_rfnb
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BC_W  = $clog2(BLOCK_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [BC_W-1:0]  BLK_CNT  = BC_W'(BLOCK_BYTES);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0] SEC_ONE  = CNT_W'(1);
  localparam logic [31:0]      ADDR_INC = 32'(ADDR_STEP);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ISSUE = 3'd2,
    XFER  = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t             state;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_cnt;
  logic [PTR_W:0]     fifo_cnt_next;
  logic               is_write;
  logic [31:0]        cur_addr;
  logic [CNT_W-1:0]   count;
  logic [BC_W-1:0]    byte_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               avail_q;
  logic               rfnb_q;
  logic               avail_rise;
  logic               rfnb_rise;
  logic               rd_byte;
  logic               wr_req;
  logic               push;
  logic               pop;
  logic               tmo_hit;

  assign avail_rise = sd_byte_avail & ~avail_q;
  assign rfnb_rise  = sd_rfnb & ~rfnb_q;
  assign rd_byte    = (state == XFER) && !is_write && !sd_ready && avail_rise;
  assign wr_req     = (state == XFER) && is_write && !sd_ready && rfnb_rise;
  assign push       = wr_valid & wr_ready;
  assign pop        = wr_req && (fifo_cnt != '0);
  assign tmo_hit    = (tmo_cnt == TMO_LIM);

  always_comb begin
    fifo_cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CNT_ONE;
      2'b01:   fifo_cnt_next = fifo_cnt - CNT_ONE;
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  // wr_ready is derived from the next count so it is exact on the cycle it is seen
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      fifo_cnt <= fifo_cnt_next;
      wr_ready <= (fifo_cnt_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= ERR_NONE;
      sectors_done <= '0;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_din       <= 8'h00;
      sd_address   <= 32'h0;
      rd_data      <= 8'h00;
      rd_valid     <= 1'b0;
      is_write     <= 1'b0;
      cur_addr     <= 32'h0;
      count        <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      avail_q      <= 1'b0;
      rfnb_q       <= 1'b0;
    end else begin
      avail_q  <= sd_byte_avail;
      rfnb_q   <= sd_rfnb;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (cmd_start) begin
            is_write     <= cmd_write;
            // cmd_lba is a sector index; ADDR_STEP scales it to the card's address unit
            cur_addr     <= cmd_lba * ADDR_INC;
            count        <= cmd_count;
            error        <= ERR_NONE;
            sectors_done <= '0;
            byte_cnt     <= '0;
            busy         <= 1'b1;
            state        <= (cmd_count == '0) ? FIN : ARM;
          end
        end
        ARM: begin
          if (sd_ready && (!is_write || fifo_cnt != '0)) begin
            sd_address <= cur_addr;
            sd_rd      <= ~is_write;
            sd_wr      <= is_write;
            tmo_cnt    <= '0;
            state      <= ISSUE;
          end else if (tmo_hit) begin
            error   <= ERR_TIMEOUT;
            tmo_cnt <= '0;
            state   <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        ISSUE: begin
          if (!sd_ready) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            tmo_cnt <= '0;
            state   <= XFER;
          end else if (tmo_hit) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            error   <= ERR_TIMEOUT;
            tmo_cnt <= '0;
            state   <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        XFER: begin
          if (sd_ready) begin
            tmo_cnt <= '0;
            // A read sector that ends early is reported as a timeout-class failure
            if (!is_write && byte_cnt != BLK_CNT) begin
              error <= ERR_TIMEOUT;
              state <= FIN;
            end else begin
              state <= NEXT;
            end
          end else if (rd_byte) begin
            rd_data  <= sd_dout;
            rd_valid <= 1'b1;
            tmo_cnt  <= '0;
            if (byte_cnt != BLK_CNT) byte_cnt <= byte_cnt + BC_ONE;
          end else if (wr_req) begin
            tmo_cnt <= '0;
            if (byte_cnt != BLK_CNT) byte_cnt <= byte_cnt + BC_ONE;
            if (fifo_cnt != '0) begin
              sd_din <= fifo_mem[rd_ptr];
            end else begin
              sd_din <= 8'hFF;
              error  <= ERR_UNDERRUN;
            end
          end else if (tmo_hit) begin
            error   <= ERR_TIMEOUT;
            tmo_cnt <= '0;
            state   <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        NEXT: begin
          sectors_done <= sectors_done + SEC_ONE;
          byte_cnt     <= '0;
          cur_addr     <= cur_addr + ADDR_INC;
          tmo_cnt      <= '0;
          // An underrun lets the current sector finish but stops the burst there
          if ((sectors_done + SEC_ONE) == count || error != ERR_NONE) begin
            state <= FIN;
          end else begin
            state <= ARM;
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          tmo_cnt <= '0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer with a behavioural SPI sd_controller
// and a host byte source; each task checks one scenario inline.
module tb_sd_block_sequencer;

  localparam int TMO = 100;

  logic        clk_25mhz = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_lba = 32'h0;
  logic [15:0] cmd_count = 16'h0;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [15:0] sectors_done;
  logic        sd_rd;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_avail;
  logic        sd_ready;
  logic        sd_rfnb;

  int checks = 0;
  int errors = 0;

  logic        model_hang = 1'b0;
  logic [31:0] addr_q[$];
  logic        kind_q[$];
  logic [7:0]  cap_q[$];
  int rdv_total = 0;
  int rd_bad = 0;
  int done_total = 0;
  int strobe_cycles = 0;
  int host_goal = 0;
  int host_sent = 0;

  sd_block_sequencer #(
    .BLOCK_BYTES(512), .ADDR_STEP(512), .CNT_W(16), .FIFO_DEPTH(16), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst(rst), .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_lba(cmd_lba), .cmd_count(cmd_count), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .error(error), .sectors_done(sectors_done), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_din(sd_din), .sd_address(sd_address), .sd_dout(sd_dout),
    .sd_byte_avail(sd_byte_avail), .sd_ready(sd_ready), .sd_rfnb(sd_rfnb)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  function automatic logic [7:0] rpat(input int k);
    return 8'(k * 5 + k / 512 + 1);
  endfunction

  function automatic logic [7:0] hpat(input int g);
    return 8'(g * 13 + 7);
  endfunction

  // Controller model: 2 cycles per byte; restarts its byte index whenever the DUT is idle
  initial begin : ctrl_model
    int  mk;
    logic w;
    mk = 0;
    sd_ready = 1'b1; sd_dout = 8'h00; sd_byte_avail = 1'b0; sd_rfnb = 1'b0;
    forever begin
      @(negedge clk_25mhz);
      if (!busy) mk = 0;
      if (!model_hang && sd_ready && (sd_rd || sd_wr)) begin
        w = sd_wr;
        addr_q.push_back(sd_address);
        kind_q.push_back(w);
        @(negedge clk_25mhz) sd_ready = 1'b0;
        @(negedge clk_25mhz);
        for (int i = 0; i < 512; i++) begin
          if (w) begin
            sd_rfnb = 1'b1;
            @(negedge clk_25mhz) sd_rfnb = 1'b0;
            cap_q.push_back(sd_din);
            @(negedge clk_25mhz);
          end else begin
            sd_dout = rpat(mk);
            mk++;
            sd_byte_avail = 1'b1;
            @(negedge clk_25mhz) sd_byte_avail = 1'b0;
            @(negedge clk_25mhz);
          end
        end
        sd_ready = 1'b1;
      end
    end
  end

  initial begin : host_drv
    bit acc;
    acc = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    forever begin
      @(negedge clk_25mhz);
      if (acc) host_sent++;
      if (host_sent < host_goal) begin
        wr_valid = 1'b1;
        wr_data  = hpat(host_sent);
      end else begin
        wr_valid = 1'b0;
      end
      acc = wr_valid && wr_ready;
    end
  end

  initial begin : out_mon
    int k;
    k = 0;
    forever begin
      @(negedge clk_25mhz);
      if (!busy) k = 0;
      if (rd_valid) begin
        if (rd_data !== rpat(k)) rd_bad++;
        k++;
        rdv_total++;
      end
      if (done) done_total++;
      if (sd_rd || sd_wr) strobe_cycles++;
    end
  end

  task automatic start_burst(input logic w, input logic [31:0] lba, input logic [15:0] cnt);
    @(negedge clk_25mhz);
    cmd_write = w; cmd_lba = lba; cmd_count = cnt; cmd_start = 1'b1;
    @(negedge clk_25mhz);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_25mhz);
    end
  endtask

  task automatic test_reset();
    logic [71:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    got = {busy, done, error, sectors_done, sd_rd, sd_wr, rd_valid, wr_ready, sd_address, rd_data, sd_din};
    checks++;
    if (got !== {1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL reset_state got %h want %h", got, {1'b0, 1'b0, 2'd0, 16'h0, 4'b0001, 48'h0});
    end
    rst = 1'b0;
    @(negedge clk_25mhz);
  endtask

  task automatic test_zero_count();
    int sbase;
    sbase = strobe_cycles;
    start_burst(1'b0, 32'd7, 16'd0);
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL zero_cycle1 busy,done got %b want 10", {busy, done}); end
    @(negedge clk_25mhz);
    checks++;
    if ({busy, done} !== 2'b01) begin errors++; $display("FAIL zero_cycle2 busy,done got %b want 01", {busy, done}); end
    @(negedge clk_25mhz);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
    checks++;
    if (strobe_cycles - sbase != 0) begin errors++; $display("FAIL zero_no_cmd got %0d want 0", strobe_cycles - sbase); end
  endtask

  task automatic test_read_burst();
    int abase, rbase, bbase, dbase;
    bit ok;
    abase = addr_q.size(); rbase = rdv_total; bbase = rd_bad; dbase = done_total;
    start_burst(1'b0, 32'd5, 16'd3);
    wait_done(5000, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL read_done got timeout want done"); end
    checks++;
    if (addr_q.size() - abase != 3) begin
      errors++; $display("FAIL read_addr_count got %0d want 3", addr_q.size() - abase);
    end else begin
      checks++;
      if ({addr_q[abase], addr_q[abase+1], addr_q[abase+2]} !== {32'hA00, 32'hC00, 32'hE00}) begin
        errors++; $display("FAIL read_addrs got %h %h %h want a00 c00 e00", addr_q[abase], addr_q[abase+1], addr_q[abase+2]);
      end
    end
    checks++;
    if (rdv_total - rbase != 1536) begin errors++; $display("FAIL read_bytes got %0d want 1536", rdv_total - rbase); end
    checks++;
    if (rd_bad - bbase != 0) begin errors++; $display("FAIL read_data got %0d bad want 0", rd_bad - bbase); end
    checks++;
    if (done_total - dbase != 1) begin errors++; $display("FAIL read_done_once got %0d want 1", done_total - dbase); end
    checks++;
    if ({error, sectors_done, busy} !== {2'd0, 16'd3, 1'b0}) begin
      errors++; $display("FAIL read_status err %0d sec %0d busy %b want 0 3 0", error, sectors_done, busy);
    end
  endtask

  task automatic test_write_burst();
    int abase, cbase, hbase, bad;
    bit ok;
    abase = addr_q.size(); cbase = cap_q.size(); hbase = host_sent;
    host_goal = host_sent + 1024;
    repeat (24) @(negedge clk_25mhz);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL write_prefill_full wr_ready got %b want 0", wr_ready); end
    start_burst(1'b1, 32'd16, 16'd2);
    wait_done(8000, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL write_done got timeout want done"); end
    checks++;
    if (addr_q.size() - abase != 2) begin
      errors++; $display("FAIL write_addr_count got %0d want 2", addr_q.size() - abase);
    end else begin
      checks++;
      if ({addr_q[abase], addr_q[abase+1]} !== {32'h2000, 32'h2200}) begin
        errors++; $display("FAIL write_addrs got %h %h want 2000 2200", addr_q[abase], addr_q[abase+1]);
      end
    end
    checks++;
    if (cap_q.size() - cbase != 1024) begin
      errors++; $display("FAIL write_bytes got %0d want 1024", cap_q.size() - cbase);
    end else begin
      bad = 0;
      for (int j = 0; j < 1024; j++) if (cap_q[cbase+j] !== hpat(hbase + j)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL write_data got %0d bad bytes want 0", bad); end
    end
    checks++;
    if ({error, sectors_done, wr_ready} !== {2'd0, 16'd2, 1'b1}) begin
      errors++; $display("FAIL write_status err %0d sec %0d rdy %b want 0 2 1", error, sectors_done, wr_ready);
    end
  endtask

  task automatic test_underrun();
    int abase, cbase, hbase, bad;
    bit ok;
    logic [7:0] want;
    abase = addr_q.size(); cbase = cap_q.size(); hbase = host_sent;
    host_goal = host_sent + 300;
    repeat (4) @(negedge clk_25mhz);
    start_burst(1'b1, 32'd0, 16'd2);
    wait_done(6000, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL underrun_done got timeout want done"); end
    checks++;
    if ({error, sectors_done} !== {2'd2, 16'd1}) begin
      errors++; $display("FAIL underrun_status err %0d sec %0d want 2 1", error, sectors_done);
    end
    checks++;
    if (addr_q.size() - abase != 1) begin errors++; $display("FAIL underrun_sectors got %0d want 1", addr_q.size() - abase); end
    checks++;
    if (cap_q.size() - cbase != 512) begin
      errors++; $display("FAIL underrun_bytes got %0d want 512", cap_q.size() - cbase);
    end else begin
      bad = 0;
      for (int j = 0; j < 512; j++) begin
        want = (j < 300) ? hpat(hbase + j) : 8'hFF;
        if (cap_q[cbase+j] !== want) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL underrun_data got %0d bad bytes want 0", bad); end
    end
  endtask

  task automatic test_timeout();
    int abase;
    bit ok;
    abase = addr_q.size();
    model_hang = 1'b1;
    host_goal = host_sent + 1;
    repeat (4) @(negedge clk_25mhz);
    start_burst(1'b1, 32'd3, 16'd1);
    wait_done(400, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL timeout_done got no done want done"); end
    checks++;
    if ({error, busy, sd_wr, sectors_done} !== {2'd1, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL timeout_status err %0d busy %b wr %b sec %0d want 1 0 0 0", error, busy, sd_wr, sectors_done);
    end
    checks++;
    if (addr_q.size() - abase != 0) begin errors++; $display("FAIL timeout_no_xfer got %0d want 0", addr_q.size() - abase); end
    model_hang = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int abase, rbase, bbase, dbase;
    bit ok;
    abase = addr_q.size(); rbase = rdv_total; bbase = rd_bad; dbase = done_total;
    start_burst(1'b0, 32'd2, 16'd1);
    checks++;
    if ({busy, error} !== {1'b1, 2'd0}) begin errors++; $display("FAIL ignore_start busy %b err %0d want 1 0", busy, error); end
    repeat (50) @(negedge clk_25mhz);
    start_burst(1'b1, 32'h77, 16'd0);
    wait_done(3000, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ignore_done got timeout want done"); end
    checks++;
    if (addr_q.size() - abase != 1) begin
      errors++; $display("FAIL ignore_sectors got %0d want 1", addr_q.size() - abase);
    end else begin
      checks++;
      if ({addr_q[abase], kind_q[abase]} !== {32'h400, 1'b0}) begin
        errors++; $display("FAIL ignore_addr got %h/%b want 400/0", addr_q[abase], kind_q[abase]);
      end
    end
    checks++;
    if ({rdv_total - rbase, rd_bad - bbase, done_total - dbase} !== {32'd512, 32'd0, 32'd1}) begin
      errors++; $display("FAIL ignore_stream bytes %0d bad %0d dones %0d want 512 0 1", rdv_total - rbase, rd_bad - bbase, done_total - dbase);
    end
    checks++;
    if ({error, sectors_done} !== {2'd0, 16'd1}) begin
      errors++; $display("FAIL ignore_status err %0d sec %0d want 0 1", error, sectors_done);
    end
  endtask

  task automatic test_reset_mid_burst();
    int rbase, bbase;
    bit ok;
    logic [71:0] got;
    rbase = rdv_total; bbase = rd_bad;
    start_burst(1'b0, 32'd0, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rdv_total - rbase >= 100) begin ok = 1'b1; break; end
      @(negedge clk_25mhz);
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL midrst_progress got %0d bytes want 100", rdv_total - rbase); end
    rst = 1'b1;
    @(negedge clk_25mhz);
    got = {busy, done, error, sectors_done, sd_rd, sd_wr, rd_valid, wr_ready, sd_address, rd_data, sd_din};
    checks++;
    if (got !== {1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL midrst_state got %h want %h", got, {1'b0, 1'b0, 2'd0, 16'h0, 4'b0001, 48'h0});
    end
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (sd_ready) begin ok = 1'b1; break; end
      @(negedge clk_25mhz);
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL midrst_ctrl_idle got busy controller want ready"); end
    repeat (2) @(negedge clk_25mhz);
    rbase = rdv_total;
    start_burst(1'b0, 32'd9, 16'd1);
    wait_done(3000, ok);
    @(negedge clk_25mhz);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL midrst_rerun_done got timeout want done"); end
    checks++;
    if (addr_q[addr_q.size()-1] !== 32'h1200) begin
      errors++; $display("FAIL midrst_rerun_addr got %h want 1200", addr_q[addr_q.size()-1]);
    end
    checks++;
    if ({rdv_total - rbase, rd_bad - bbase} !== {32'd512, 32'd0}) begin
      errors++; $display("FAIL midrst_rerun_stream bytes %0d bad %0d want 512 0", rdv_total - rbase, rd_bad - bbase);
    end
    checks++;
    if ({error, sectors_done} !== {2'd0, 16'd1}) begin
      errors++; $display("FAIL midrst_rerun_status err %0d sec %0d want 0 1", error, sectors_done);
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_read_burst();
    test_write_burst();
    test_underrun();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
